// File: rtl/rom_pkg.sv
// rom_pkg: shared FSM encoding and default widths
// for the ROM stream reader.
package rom_pkg;

    localparam int ROM_ADDR_WIDTH = 8;
    localparam int ROM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO whose push and pop may
// coincide on any cycle, including when full.
module sync_fifo
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // a full FIFO still accepts a word if one leaves
        do_push  = push && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: bursts words from a 1-cycle ROM into a
// valid/ready stream. ROM_STREAM_READER_CHECKSUM_EN adds checksum.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   issued_nx;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occ;
    logic                  pop;

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_data(rom_data),
        .pop      (pop),
        .head     (m_data),
        .count    (fifo_count)
    );

    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid && m_ready;
    assign occ       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign issued_nx = issued_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        rom_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_FETCH;
                        base_d   = base_addr;
                        len_d    = length;
                        issued_d = '0;
                    end
                end
            end
            ST_FETCH: begin
                // never issue more than the FIFO can absorb
                rom_en = (issued_q < len_q) && (occ < DEPTH_V);
                if (rom_en) begin
                    issued_d = issued_nx;
                    if (issued_nx == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && !inflight_q
                    && fifo_count == CW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d = rom_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign rom_addr = base_q + issued_q[ADDR_WIDTH-1:0];

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ m_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed bursts against a queue model
// of the expected ROM words and issue addresses.
module tb_rom_stream_reader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    rom_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_iss = 0;
    int n_hs = 0;
    logic chk_en = 1'b0;

    logic [DW-1:0] rom_mem [256];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    logic [AW-1:0] iss_log [$];
    int            hs_cyc [$];
    logic [DW-1:0] csum_m;
    logic [DW-1:0] prev_data;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] e_word;
    logic [DW-1:0] stall_head;
    int            burst_cyc;
    int            dcyc;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ROM: one-cycle registered read, garbage when disabled
    always @(posedge clk) begin
        rom_data <= rom_en ? rom_mem[rom_addr] : DW'($urandom);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (rom_en) begin
                iss_log.push_back(rom_addr);
                if (addr_q.size() == 0) begin
                    chk("unexpected_rom_en", 1, 0);
                end else begin
                    chk("rom_addr", rom_addr, addr_q.pop_front());
                end
                chk("outstanding_le_depth",
                    64'((n_iss + 1 - n_hs) <= DEPTH), 1);
                n_iss++;
            end
            if (hold_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e_word = exp_q.pop_front();
                    chk("m_data", m_data, e_word);
                    csum_m = csum_m ^ e_word;
                end
                hs_cyc.push_back(cyc);
                n_hs++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic load_model(input logic [AW-1:0] b,
                              input int l);
        logic [AW-1:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back(rom_mem[a]);
        end
        csum_m = '0;
        iss_log.delete();
        hs_cyc.delete();
    endtask

    task automatic run_burst(input logic [AW-1:0] b,
                             input int l,
                             input int stall,
                             input int mode,
                             input int poke,
                             output int done_cyc);
        int iss0;
        int lim;
        load_model(b, l);
        iss0 = n_iss;
        lim = (l < DEPTH) ? l : DEPTH;
        done_cyc = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = (AW+1)'(l);
        m_ready = (stall == 0);
        burst_cyc = cyc;
        for (int k = 1; k < 2000; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 1 && l > 0) chk("busy_on_start", busy, 1);
            if (k == poke) begin
                start = 1'b1;
                base_addr = 8'd100;
                length = 9'd5;
            end
            if (stall > 0 && k == stall) begin
                chk("stall_issues", n_iss - iss0, lim);
                chk("stall_valid", m_valid, 1);
                stall_head = m_data;
            end
            if (k < stall) m_ready = 1'b0;
            else if (mode == 0) m_ready = 1'b1;
            else m_ready = ((k % 3) != 1);
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("done_busy_low", busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        chk("checksum_model", checksum, csum_m);
`endif
        m_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = 32'hC0DE_0000 | DW'(i * 3);
        end
        rom_mem[0] = 32'hDEADBEEF;
        rom_mem[1] = 32'h12345678;
        rom_mem[2] = 32'hABCDEF01;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_m_data", m_data, 0);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // three words back to back, done one cycle later
        run_burst(8'd0, 3, 0, 0, -1, dcyc);
        chk("b1_beats", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("b1_consecutive", hs_cyc[2] - hs_cyc[0], 2);
            chk("b1_done_after", dcyc - hs_cyc[2], 1);
        end
        chk("b1_latency", dcyc - burst_cyc, 6);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        chk("b1_checksum", checksum,
            32'hDEADBEEF ^ 32'h12345678 ^ 32'hABCDEF01);
`endif

        // address wrap at the top of the ROM
        run_burst(8'd254, 4, 0, 0, -1, dcyc);
        chk("wrap_count", iss_log.size(), 4);
        if (iss_log.size() == 4) begin
            chk("wrap_a0", iss_log[0], 254);
            chk("wrap_a1", iss_log[1], 255);
            chk("wrap_a2", iss_log[2], 0);
            chk("wrap_a3", iss_log[3], 1);
        end

        // backpressure: issue stalls at FIFO depth
        run_burst(8'd0, 8, 20, 0, -1, dcyc);
        chk("stall_head", stall_head, 32'hDEADBEEF);
        chk("stall_beats", hs_cyc.size(), 8);

        // zero length completes immediately
        run_burst(8'd5, 0, 0, 0, -1, dcyc);
        chk("len0_done_next", dcyc - burst_cyc, 1);
        chk("len0_no_issue", iss_log.size(), 0);

        // start while busy is ignored
        run_burst(8'd0, 3, 6, 0, 3, dcyc);
        chk("poke_beats", hs_cyc.size(), 3);

        // sustained rate and a choppy ready pattern
        run_burst(8'd20, 10, 0, 0, -1, dcyc);
        if (hs_cyc.size() == 10) begin
            chk("rate_span", hs_cyc[9] - hs_cyc[0], 9);
        end else begin
            chk("rate_beats", hs_cyc.size(), 10);
        end
        run_burst(8'd40, 12, 0, 1, -1, dcyc);
        chk("choppy_beats", hs_cyc.size(), 12);

        // reset in the middle of a long burst
        load_model(8'd0, 16);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 8'd0;
        length = 9'd16;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_burst", 64'(n_hs > 0 && exp_q.size() > 0), 1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_rom_en", rom_en, 0);
        chk("mrst_done", done, 0);
        chk("mrst_m_data", m_data, 0);
        chk("mrst_rom_addr", rom_addr, 0);
        exp_q.delete();
        addr_q.delete();
        n_iss = 0;
        n_hs = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        run_burst(8'd2, 3, 0, 0, -1, dcyc);
        chk("post_rst_beats", hs_cyc.size(), 3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
